// File: rtl/ramp_sweep_gen.sv
// Signed accumulator sweep generator: triangle / sawtooth / single-shot / park with growing amplitude.
// Define RAMP_SATURATE_EN to clamp accumulator and sweep limits instead of letting them wrap.
module ramp_sweep_gen #(
    parameter int RAMP_OUTPUT_WIDTH   = 14,
    parameter int RAMP_INTERNAL_WIDTH = 32,
    parameter int CYCLE_COUNT_WIDTH   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [1:0]                            mode,
    input  logic                                  hold,
    input  logic signed [RAMP_INTERNAL_WIDTH-1:0] ramplitude,
    input  logic signed [RAMP_INTERNAL_WIDTH-1:0] ramplitude_step,
    input  logic signed [RAMP_INTERNAL_WIDTH-1:0] ramp_step,
    input  logic signed [RAMP_INTERNAL_WIDTH-1:0] ramp_start_offset,
    output logic [RAMP_OUTPUT_WIDTH-1:0]          ramp_output,
    output logic signed [RAMP_INTERNAL_WIDTH-1:0] ramp_acc,
    output logic                                  ramp_corner,
    output logic                                  ramp_start,
    output logic                                  ramp_dir_up,
    output logic                                  ramp_done,
    output logic [CYCLE_COUNT_WIDTH-1:0]          ramp_cycles
);

    localparam int IW = RAMP_INTERNAL_WIDTH;
    localparam int OW = RAMP_OUTPUT_WIDTH;
    localparam int CW = CYCLE_COUNT_WIDTH;

    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;
    localparam logic [1:0] MODE_PARK   = 2'd3;

    localparam logic signed [IW-1:0] ZERO    = '0;
    localparam logic [CW-1:0]        CYC_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_PARK,
        ST_UP,
        ST_DOWN,
        ST_DONE
    } state_t;

`ifdef RAMP_SATURATE_EN
    localparam logic signed [IW-1:0] ACC_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] ACC_MIN = {1'b1, {(IW-1){1'b0}}};

    function automatic logic signed [IW-1:0] acc_add(input logic signed [IW-1:0] a,
                                                     input logic signed [IW-1:0] b);
        logic signed [IW:0] s;
        s = {a[IW-1], a} + {b[IW-1], b};
        if (s[IW] != s[IW-1]) return s[IW] ? ACC_MIN : ACC_MAX;
        return s[IW-1:0];
    endfunction

    function automatic logic signed [IW-1:0] acc_sub(input logic signed [IW-1:0] a,
                                                     input logic signed [IW-1:0] b);
        logic signed [IW:0] s;
        s = {a[IW-1], a} - {b[IW-1], b};
        if (s[IW] != s[IW-1]) return s[IW] ? ACC_MIN : ACC_MAX;
        return s[IW-1:0];
    endfunction
`else
    function automatic logic signed [IW-1:0] acc_add(input logic signed [IW-1:0] a,
                                                     input logic signed [IW-1:0] b);
        return a + b;
    endfunction

    function automatic logic signed [IW-1:0] acc_sub(input logic signed [IW-1:0] a,
                                                     input logic signed [IW-1:0] b);
        return a - b;
    endfunction
`endif

    // Amplitude growth is always limited to the programmed ramplitude, independent of saturation.
    function automatic logic signed [IW-1:0] amp_grow(input logic signed [IW-1:0] amp,
                                                      input logic signed [IW-1:0] inc,
                                                      input logic signed [IW-1:0] lim);
        logic signed [IW:0] s;
        logic signed [IW:0] l;
        s = {amp[IW-1], amp} + {inc[IW-1], inc};
        l = {lim[IW-1], lim};
        if (s > l) return lim;
        return s[IW-1:0];
    endfunction

    logic [1:0]           mode_r;
    logic signed [IW-1:0] ampl_r;
    logic signed [IW-1:0] amp_step_r;
    logic signed [IW-1:0] step_r;

    state_t               state, state_nxt;
    logic signed [IW-1:0] acc, acc_nxt;
    logic signed [IW-1:0] amp_cur, amp_nxt;
    logic                 corner, corner_nxt;
    logic                 start, start_nxt;
    logic                 done, done_nxt;
    logic [CW-1:0]        cycles, cycles_nxt;

    logic signed [IW-1:0] lim_hi, lim_lo, acc_up, acc_dn, restart_amp;
    state_t               restart_state;
    logic                 mode_chg;
    logic                 grow;

    assign lim_hi        = acc_add(ramp_start_offset, amp_cur);
    assign lim_lo        = acc_sub(ramp_start_offset, amp_cur);
    assign acc_up        = acc_add(acc, step_r);
    assign acc_dn        = acc_sub(acc, step_r);
    assign restart_amp   = (ramplitude_step == ZERO) ? ramplitude : ramplitude_step;
    assign restart_state = (mode == MODE_PARK) ? ST_PARK : ST_UP;
    assign mode_chg      = (mode != mode_r);

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        amp_nxt    = amp_cur;
        corner_nxt = 1'b0;
        start_nxt  = 1'b0;
        done_nxt   = done;
        cycles_nxt = cycles;
        grow       = 1'b0;

        if (mode_chg) begin
            state_nxt = restart_state;
            acc_nxt   = ramp_start_offset;
            amp_nxt   = restart_amp;
            done_nxt  = 1'b0;
        end else if (!hold) begin
            case (state)
                ST_UP: begin
                    if (step_r != ZERO) begin
                        if (acc >= lim_hi) begin
                            corner_nxt = 1'b1;
                            grow       = 1'b1;
                            if (mode_r == MODE_SAW) begin
                                acc_nxt    = lim_lo;
                                start_nxt  = 1'b1;
                                cycles_nxt = cycles + CYC_ONE;
                            end else begin
                                acc_nxt   = acc_dn;
                                state_nxt = ST_DOWN;
                            end
                        end else begin
                            acc_nxt = acc_up;
                        end
                    end
                end
                ST_DOWN: begin
                    if (step_r != ZERO) begin
                        if (acc <= lim_lo) begin
                            corner_nxt = 1'b1;
                            start_nxt  = 1'b1;
                            cycles_nxt = cycles + CYC_ONE;
                            grow       = 1'b1;
                            if (mode_r == MODE_SINGLE) begin
                                acc_nxt   = ramp_start_offset;
                                state_nxt = ST_DONE;
                                done_nxt  = 1'b1;
                            end else begin
                                acc_nxt   = acc_up;
                                state_nxt = ST_UP;
                            end
                        end else begin
                            acc_nxt = acc_dn;
                        end
                    end
                end
                default: acc_nxt = ramp_start_offset;
            endcase

            // A reduced ramplitude pulls amp_cur down even between corners.
            if (amp_step_r == ZERO) amp_nxt = ampl_r;
            else amp_nxt = amp_grow(amp_cur, grow ? amp_step_r : ZERO, ampl_r);
        end
    end

    always_ff @(posedge clk) begin
        mode_r     <= mode;
        ampl_r     <= ramplitude;
        amp_step_r <= ramplitude_step;
        step_r     <= ramp_step;
        if (rst) begin
            state   <= restart_state;
            acc     <= ramp_start_offset;
            amp_cur <= restart_amp;
            corner  <= 1'b0;
            start   <= 1'b0;
            done    <= 1'b0;
            cycles  <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            amp_cur <= amp_nxt;
            corner  <= corner_nxt;
            start   <= start_nxt;
            done    <= done_nxt;
            cycles  <= cycles_nxt;
        end
    end

    assign ramp_acc    = acc;
    assign ramp_output = acc[IW-1 -: OW];
    assign ramp_corner = corner;
    assign ramp_start  = start;
    assign ramp_dir_up = (state != ST_DOWN);
    assign ramp_done   = done;
    assign ramp_cycles = cycles;

endmodule
